// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder.
//   state_t  : controller states (IDLE, RUN, DONE)
//   NIBBLE_W : width of one serial step in bits
package adder_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : adder_pkg

// File: rtl/nibble_add_correct.sv
// One nibble step: raw add of x and y (no carry-in), then an increment
// correction by c through a four half-adder chain.
//   x, y : operand nibbles
//   c    : running carry applied as the increment
//   r    : corrected nibble result
//   co   : raw carry-out OR increment carry-out
//   c3   : carry into bit 3 of x + y + c (feeds the overflow flag)
module nibble_add_correct
   import adder_pkg::*;
(
   input  logic [NIBBLE_W-1:0] x,
   input  logic [NIBBLE_W-1:0] y,
   input  logic                c,
   output logic [NIBBLE_W-1:0] r,
   output logic                co,
   output logic                c3
);

   logic [NIBBLE_W:0] raw;
   logic              inc_c;

   always_comb begin
      raw   = {1'b0, x} + {1'b0, y};
      inc_c = c;
      for (int i = 0; i < NIBBLE_W; i++) begin
         r[i]  = raw[i] ^ inc_c;
         inc_c = raw[i] & inc_c;
      end
      // Both carries can never be set together; the OR merges the two paths.
      co = raw[NIBBLE_W] | inc_c;
      // r[3] is the true sum bit of x + y + c, so the carry into it falls out by XOR.
      c3 = x[NIBBLE_W-1] ^ y[NIBBLE_W-1] ^ r[NIBBLE_W-1];
   end

endmodule : nibble_add_correct

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder, one nibble per clock, LSB nibble first.
// Valid/ready on both the operand side and the result side.
//   clk, rst_n           : clock, async active-low reset
//   in_valid / in_ready  : operand handshake (a, b, cin)
//   out_valid / out_ready: result handshake (sum, cout, ovf)
//   sum  : a + b + cin modulo 2^WIDTH
//   cout : carry out of the MSB nibble
//   ovf  : two's-complement overflow
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one nibble step per cycle, counter selects the nibble
// DONE  | result held with out_valid high until out_ready
module nibble_serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NIBBLES = WIDTH / NIBBLE_W;
   localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   state_t             state, state_nx;
   logic [WIDTH-1:0]   a_q, b_q, sum_q;
   logic               carry_q, cout_q, ovf_q;
   logic [CNT_W-1:0]   cnt;
   logic               last;
   logic               accept;

   logic [NIBBLE_W-1:0] x_nib, y_nib, r_nib;
   logic                co_nib, c3_nib;

   assign last   = (cnt == CNT_W'(NIBBLES - 1));
   assign accept = (state == IDLE) && in_valid;

   assign x_nib = a_q[NIBBLE_W*int'(cnt) +: NIBBLE_W];
   assign y_nib = b_q[NIBBLE_W*int'(cnt) +: NIBBLE_W];

   nibble_add_correct u_step (
      .x  (x_nib),
      .y  (y_nib),
      .c  (carry_q),
      .r  (r_nib),
      .co (co_nib),
      .c3 (c3_nib)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = RUN;
         end
         RUN: begin
            if (last) state_nx = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         cnt     <= '0;
      end else if (accept) begin
         a_q     <= a;
         b_q     <= b;
         carry_q <= cin;
         cnt     <= '0;
         sum_q   <= '0;
      end else if (state == RUN) begin
         sum_q[NIBBLE_W*int'(cnt) +: NIBBLE_W] <= r_nib;
         carry_q <= co_nib;
         if (last) begin
            cout_q <= co_nib;
            ovf_q  <= c3_nib ^ co_nib;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule : nibble_serial_adder
